// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 host receiver turning set-2 frames into key make/break strobes
module ps2_scancode_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 56000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       strb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext,
  output logic       err
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DECODE} state_t;
  state_t state, state_n;
  logic [1:0] c_sync, d_sync;
  logic [FILTER-1:0] filt;
  logic fclk, fclk_d, fall, d;
  logic [2:0] cnt, cnt_n, skip, skip_n;
  logic [7:0] sr, sr_n, code_n;
  logic [TW-1:0] tmo, tmo_n;
  logic par, par_n, brk, brk_n, exf, exf_n, strb_n, err_n, make_n, ext_n;
  assign fall = fclk_d & ~fclk;
  assign d = d_sync[1];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      c_sync <= '0;
      d_sync <= '0;
      filt   <= '1;
      fclk   <= 1'b1;
      fclk_d <= 1'b1;
      state  <= IDLE;
      cnt    <= '0;
      sr     <= '0;
      par    <= 1'b0;
      tmo    <= '0;
      brk    <= 1'b0;
      exf    <= 1'b0;
      skip   <= '0;
      strb   <= 1'b0;
      err    <= 1'b0;
      make   <= 1'b1;
      code   <= '0;
      ext    <= 1'b0;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
      filt   <= {filt[FILTER-2:0], c_sync[1]};
      fclk   <= (&filt) | (fclk & |filt);
      fclk_d <= fclk;
      state  <= state_n;
      cnt    <= cnt_n;
      sr     <= sr_n;
      par    <= par_n;
      tmo    <= tmo_n;
      brk    <= brk_n;
      exf    <= exf_n;
      skip   <= skip_n;
      strb   <= strb_n;
      err    <= err_n;
      make   <= make_n;
      code   <= code_n;
      ext    <= ext_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    par_n   = par;
    tmo_n   = tmo;
    brk_n   = brk;
    exf_n   = exf;
    skip_n  = skip;
    strb_n  = 1'b0;
    err_n   = 1'b0;
    make_n  = make;
    code_n  = code;
    ext_n   = ext;
    case (state)
      IDLE:
        if (fall) begin
          state_n = d ? IDLE : DATA;
          err_n   = d;
          cnt_n   = '0;
          tmo_n   = '0;
        end
      DATA, PARITY, STOP:
        if (fall) begin
          tmo_n = '0;
          if (state == DATA) begin
            sr_n    = {d, sr[7:1]};
            cnt_n   = cnt + 3'd1;
            state_n = (cnt == 3'd7) ? PARITY : DATA;
          end else if (state == PARITY) begin
            par_n   = d;
            state_n = STOP;
          end else if (d && (^sr ^ par)) begin
            state_n = DECODE;
          end else begin
            err_n   = 1'b1;
            brk_n   = 1'b0;
            exf_n   = 1'b0;
            state_n = IDLE;
          end
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          brk_n   = 1'b0;
          exf_n   = 1'b0;
          state_n = IDLE;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      DECODE: begin
        state_n = IDLE;
        if (skip != 3'd0) begin
          skip_n = skip - 3'd1;
        end else if (sr == 8'hE1) begin
          skip_n = 3'd7;
          brk_n  = 1'b0;
          exf_n  = 1'b0;
        end else if (sr == 8'hF0) begin
          brk_n = 1'b1;
        end else if (sr == 8'hE0) begin
          exf_n = 1'b1;
        end else if (sr inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
          brk_n = 1'b0;
          exf_n = 1'b0;
        end else begin
          strb_n = 1'b1;
          code_n = sr;
          make_n = brk;
          ext_n  = exf;
          brk_n  = 1'b0;
          exf_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: directed and randomized frame checks against a byte-level decode model
module tb_ps2_scancode_rx;
  localparam int H   = 30;
  localparam int TMO = 2000;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;
  logic strb, make, ext, err;
  logic [7:0] code;
  int checks = 0;
  int passes = 0;
  int fails = 0;
  int errs = 0;
  int e0, exp_errs, m_skip;
  logic m_brk, m_ext;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  ps2_scancode_rx #(.FILTER(8), .TIMEOUT(TMO)) dut (
    .clock(clock),
    .reset(reset),
    .ps2c(ps2c),
    .ps2d(ps2d),
    .strb(strb),
    .make(make),
    .code(code),
    .ext(ext),
    .err(err)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (strb) got_q.push_back({code, make, ext});
    if (err) errs++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic bit_out(input logic b);
    ps2d = b;
    clks(H);
    ps2c = 1'b0;
    clks(H);
    ps2c = 1'b1;
  endtask
  task automatic frame(input logic [7:0] b, input logic bad_par, input int nbits, input int glitch);
    logic [10:0] f;
    f = {1'b1, ~^b ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bit_out(f[i]);
      if (i == glitch) begin
        clks(H / 3);
        ps2c = 1'b0;
        clks(3);
        ps2c = 1'b1;
      end
    end
    ps2d = 1'b1;
    clks(H);
  endtask
  task automatic send(input logic [7:0] b);
    frame(b, 1'b0, 11, -1);
  endtask
  task automatic expect_ev(input string tag, input logic [7:0] c, input logic mk, input logic e);
    check({tag, " count"}, got_q.size(), 1);
    if (got_q.size() > 0) check({tag, " event"}, {22'd0, got_q[0]}, {22'd0, c, mk, e});
    got_q.delete();
  endtask
  task automatic expect_none(input string tag);
    check({tag, " no strobe"}, got_q.size(), 0);
    got_q.delete();
  endtask
  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) begin
      m_skip = 7;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else begin
      exp_q.push_back({b, m_brk, m_ext});
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask
  initial begin
    logic [7:0] b;
    logic bad;
    int r;
    clks(3);
    check("reset strb", strb, 0);
    check("reset make", make, 1);
    check("reset code", code, 0);
    check("reset ext", ext, 0);
    check("reset err", err, 0);
    reset = 1'b1;
    clks(20);
    send(8'h1C);
    expect_ev("1C", 8'h1C, 1'b0, 1'b0);
    send(8'hF0);
    send(8'h1C);
    expect_ev("F0 1C", 8'h1C, 1'b1, 1'b0);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    expect_ev("E0 F0 75", 8'h75, 1'b1, 1'b1);
    send(8'hF0);
    send(8'hE0);
    send(8'h75);
    expect_ev("F0 E0 75", 8'h75, 1'b1, 1'b1);
    send(8'hF0);
    send(8'hF0);
    send(8'h1C);
    expect_ev("F0 F0 1C", 8'h1C, 1'b1, 1'b0);
    e0 = errs;
    frame(8'h1C, 1'b1, 11, -1);
    check("parity err", errs - e0, 1);
    expect_none("parity");
    send(8'h1B);
    expect_ev("after parity 1B", 8'h1B, 1'b0, 1'b0);
    e0 = errs;
    frame(8'h55, 1'b0, 5, -1);
    clks(TMO + 20);
    check("timeout err", errs - e0, 1);
    expect_none("timeout");
    send(8'h29);
    expect_ev("after timeout 29", 8'h29, 1'b0, 1'b0);
    e0 = errs;
    bit_out(1'b1);
    clks(H);
    check("idle no start err", errs - e0, 1);
    send(8'h1C);
    expect_ev("after idle err 1C", 8'h1C, 1'b0, 1'b0);
    e0 = errs;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    expect_none("pause");
    check("pause no err", errs - e0, 0);
    send(8'h5A);
    expect_ev("after pause 5A", 8'h5A, 1'b0, 1'b0);
    send(8'hE0);
    send(8'hAA);
    send(8'hFA);
    send(8'h1C);
    expect_ev("reply clears prefix", 8'h1C, 1'b0, 1'b0);
    e0 = errs;
    send(8'hE0);
    frame(8'h3A, 1'b0, 11, 3);
    expect_ev("glitch 3A", 8'h3A, 1'b0, 1'b1);
    check("glitch no err", errs - e0, 0);
    frame(8'h66, 1'b0, 5, -1);
    reset = 1'b0;
    #1;
    check("midreset strb", strb, 0);
    check("midreset make", make, 1);
    check("midreset code", code, 0);
    check("midreset ext", ext, 0);
    check("midreset err", err, 0);
    clks(5);
    reset = 1'b1;
    clks(20);
    got_q.delete();
    send(8'h29);
    expect_ev("after reset 29", 8'h29, 1'b0, 1'b0);
    m_skip = 0;
    m_brk = 1'b0;
    m_ext = 1'b0;
    exp_errs = 0;
    e0 = errs;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 19);
      b = (r < 4) ? 8'hF0 : (r < 7) ? 8'hE0 : (r == 7) ? 8'hE1 : (r == 8) ? 8'hFA :
          (r == 9) ? 8'hAA : 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      frame(b, bad, 11, -1);
      if (bad) begin
        exp_errs++;
        m_brk = 1'b0;
        m_ext = 1'b0;
      end else model_byte(b);
    end
    check("random event count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("random event %0d", i), {22'd0, got_q[i]}, {22'd0, exp_q[i]});
    check("random err count", errs - e0, exp_errs);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
